// File: rtl/can_tx_scheduler_pkg.sv
// Shared types and encodings for the CAN TX mailbox scheduler.
// Feature macro: CAN_TXSCHED_PRIO_EN selects ID-priority arbitration.
package can_tx_scheduler_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_LD_ID,
        S_LD_D0,
        S_LD_D1,
        S_STROBE,
        S_GAP,
        S_POLL,
        S_EVAL
    } state_t;

    localparam logic [1:0] HREG_ID   = 2'b00;
    localparam logic [1:0] HREG_CTRL = 2'b01;
    localparam logic [1:0] HREG_D0   = 2'b10;
    localparam logic [1:0] HREG_D1   = 2'b11;

    localparam logic [1:0] RS_TXID = 2'b00;
    localparam logic [1:0] RS_CTRL = 2'b01;
    localparam logic [1:0] RS_TXD0 = 2'b10;
    localparam logic [1:0] RS_TXD1 = 2'b11;

    localparam int ST_RTS  = 8;
    localparam int ST_LOST = 9;
    localparam int ST_BITF = 10;
    localparam int ST_ACKF = 11;

    localparam int CTL_REQ   = 8;
    localparam int CTL_ABORT = 9;

    // Arbitration key: std IDs sort ahead of ext IDs sharing the base ID.
    function automatic logic [29:0] prio_key(input logic [31:0] w);
        return w[31] ? {w[28:18], 1'b1, w[17:0]} : {w[10:0], 1'b0, 18'h0};
    endfunction

endpackage

// File: rtl/can_tx_scheduler_prio_sel.sv
// Combinational mailbox winner selection (ID priority or round-robin).
// Feature macro: CAN_TXSCHED_PRIO_EN.
module can_tx_prio_sel
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB = 4,
    parameter int MBW    = $clog2(NUM_MB)
) (
    input  logic [NUM_MB-1:0]       pending,
    input  logic [NUM_MB-1:0][31:0] id_words,
    input  logic [MBW-1:0]          rr_start,
    output logic [MBW-1:0]          winner
);

`ifdef CAN_TXSCHED_PRIO_EN
    logic [29:0] best;
    logic        found;

    always_comb begin
        winner = '0;
        best   = '1;
        found  = 1'b0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending[i] && (!found || prio_key(id_words[i]) < best)) begin
                found  = 1'b1;
                best   = prio_key(id_words[i]);
                winner = MBW'(i);
            end
        end
    end
`else
    int idx;

    // Descending scan so the nearest pending slot after rr_start wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int k = NUM_MB - 1; k >= 0; k--) begin
            idx = (int'(rr_start) + k) % NUM_MB;
            if (pending[idx]) winner = MBW'(idx);
        end
    end
`endif

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN TX mailbox scheduler: loads frames into the CAN core and tracks results.
// Feature macro: CAN_TXSCHED_PRIO_EN (ID-priority select, else round-robin).
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int RETRY_MAX = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hwe,
    input  logic [$clog2(NUM_MB)-1:0] hmb,
    input  logic [1:0]                hreg,
    input  logic [31:0]               hwdata,
    input  logic [NUM_MB-1:0]         done_clr,
    output logic [NUM_MB-1:0]         mb_pending,
    output logic [NUM_MB-1:0]         mb_done,
    output logic [NUM_MB-1:0]         mb_err,
    output logic                      busy,
    output logic [$clog2(NUM_MB)-1:0] cur_mb,
    output logic                      irq_done,
    output logic                      core_cs,
    output logic [1:0]                core_rs,
    output logic [3:0]                core_bytesel,
    output logic [31:0]               core_d,
    input  logic [31:0]               core_q
);

    localparam int MBW = $clog2(NUM_MB);
    localparam int RW  = $clog2(RETRY_MAX + 1);

    state_t state, state_nx;

    logic [NUM_MB-1:0][31:0] id_mem;
    logic [NUM_MB-1:0][31:0] d0_mem;
    logic [NUM_MB-1:0][31:0] d1_mem;
    logic [3:0]              dlc_mem [NUM_MB];

    logic [RW-1:0]     retry_cnt [NUM_MB];
    logic [NUM_MB-1:0] abort_req;
    logic [MBW-1:0]    rr_ptr;
    logic [MBW-1:0]    winner;
    logic              lostf, bitf, ackf;

    logic              inflight, wr_hit;
    logic              host_req, host_abort, abort_hit, abort_direct;
    logic              eval_abort, ok, retry_full;
    logic              fin_done, fin_err, retry_inc;
    logic [NUM_MB-1:0] cur_mask, hmb_mask, fin_mask, remain;

    assign inflight = !(state inside {S_IDLE, S_SELECT});
    assign wr_hit   = hwe && inflight && (hmb == cur_mb);

    assign host_req   = hwe && hreg == HREG_CTRL && hwdata[CTL_REQ]
                        && !mb_pending[hmb];
    assign host_abort = hwe && hreg == HREG_CTRL && hwdata[CTL_ABORT];
    assign abort_hit    = host_abort && wr_hit;
    assign abort_direct = host_abort && !wr_hit;

    assign cur_mask = NUM_MB'(1) << cur_mb;
    assign hmb_mask = NUM_MB'(1) << hmb;

    assign eval_abort = abort_req[cur_mb] || abort_hit;
    assign ok         = !lostf && !bitf && ackf;
    assign retry_full = (retry_cnt[cur_mb] + RW'(1)) == RW'(RETRY_MAX);

    assign fin_done  = state == S_EVAL && !eval_abort && ok;
    assign fin_err   = state == S_EVAL
                       && (eval_abort || (!ok && !lostf && retry_full));
    assign retry_inc = state == S_EVAL && !eval_abort && !ok && !lostf
                       && !retry_full;
    assign fin_mask  = (fin_done || fin_err) ? cur_mask : '0;
    assign remain    = mb_pending & ~fin_mask;

    assign busy     = state != S_IDLE;
    assign irq_done = |{mb_done, mb_err};

    can_tx_prio_sel #(
        .NUM_MB(NUM_MB),
        .MBW   (MBW)
    ) u_sel (
        .pending (mb_pending),
        .id_words(id_mem),
        .rr_start(rr_ptr),
        .winner  (winner)
    );

    // Mailbox contents survive reset; the host reloads them as needed.
    always_ff @(posedge clk) begin
        if (hwe && !wr_hit) begin
            unique case (hreg)
                HREG_ID: id_mem[hmb] <= hwdata;
                HREG_D0: d0_mem[hmb] <= hwdata;
                HREG_D1: d1_mem[hmb] <= hwdata;
                default: ;
            endcase
        end
        if (host_req) dlc_mem[hmb] <= hwdata[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_mb     <= '0;
            rr_ptr     <= '0;
            mb_pending <= '0;
            mb_done    <= '0;
            mb_err     <= '0;
            abort_req  <= '0;
            lostf      <= 1'b0;
            bitf       <= 1'b0;
            ackf       <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) retry_cnt[i] <= '0;
        end else begin
            state      <= state_nx;
            mb_pending <= (mb_pending | (host_req ? hmb_mask : '0))
                          & ~(abort_direct ? hmb_mask : '0) & ~fin_mask;
            mb_done    <= (mb_done & ~done_clr)
                          | (fin_done ? cur_mask : '0);
            mb_err     <= (mb_err & ~done_clr)
                          | (fin_err ? cur_mask : '0)
                          | (abort_direct ? hmb_mask : '0);
            if (state == S_SELECT) cur_mb <= winner;
            if (state == S_POLL && !core_q[ST_RTS]) begin
                lostf <= core_q[ST_LOST];
                bitf  <= core_q[ST_BITF];
                ackf  <= core_q[ST_ACKF];
            end
            if (state == S_EVAL) begin
                abort_req[cur_mb] <= 1'b0;
            end else if (abort_hit) begin
                abort_req[cur_mb] <= 1'b1;
            end
            if (fin_done || fin_err) retry_cnt[cur_mb] <= '0;
            else if (retry_inc) retry_cnt[cur_mb] <= retry_cnt[cur_mb] + RW'(1);
            if (fin_done) begin
                rr_ptr <= (int'(cur_mb) == NUM_MB - 1) ? '0 : cur_mb + MBW'(1);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        core_cs      = 1'b0;
        core_rs      = 2'b00;
        core_bytesel = 4'b0000;
        core_d       = 32'h0;
        unique case (state)
            S_IDLE:   if (|mb_pending) state_nx = S_SELECT;
            S_SELECT: state_nx = (|mb_pending) ? S_LD_ID : S_IDLE;
            S_LD_ID: begin
                core_cs      = 1'b1;
                core_rs      = RS_TXID;
                core_bytesel = 4'b1111;
                core_d       = id_mem[cur_mb];
                state_nx     = S_LD_D0;
            end
            S_LD_D0: begin
                core_cs      = 1'b1;
                core_rs      = RS_TXD0;
                core_bytesel = 4'b1111;
                core_d       = d0_mem[cur_mb];
                state_nx     = S_LD_D1;
            end
            S_LD_D1: begin
                core_cs      = 1'b1;
                core_rs      = RS_TXD1;
                core_bytesel = 4'b1111;
                core_d       = d1_mem[cur_mb];
                state_nx     = S_STROBE;
            end
            // Low bytes only: bauddiv and irqen sit in the upper bytes.
            S_STROBE: begin
                core_cs      = 1'b1;
                core_rs      = RS_CTRL;
                core_bytesel = 4'b0011;
                core_d       = 32'h100 | {28'h0, dlc_mem[cur_mb]};
                state_nx     = S_GAP;
            end
            S_GAP:  state_nx = S_POLL;
            S_POLL: begin
                core_cs = 1'b1;
                core_rs = RS_CTRL;
                if (!core_q[ST_RTS]) state_nx = S_EVAL;
            end
            S_EVAL:  state_nx = (|remain) ? S_SELECT : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter NUM_MB, default 4: number of TX mailboxes, range 2..8.
REQ-002 Parameter RETRY_MAX, default 3: error retries per mailbox before it is abandoned.
REQ-003 Port clk, input, 1 bit: clock, rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port hwe, input, 1 bit: host mailbox write strobe.
REQ-006 Port hmb, input, $clog2(NUM_MB) bits: host-selected mailbox.
REQ-007 Port hreg, input, 2 bits: 00 = ID word {ext,rtr,x,id[28:0]}; 01 = control {abort bit9, request bit8, dlc[3:0]}; 10 = data0; 11 = data1.
REQ-008 Port hwdata, input, 32 bits: host write data.
REQ-009 Port done_clr, input, NUM_MB bits: write-1-to-clear for mb_done and mb_err.
REQ-010 Port mb_pending, output, NUM_MB bits: mailbox has a queued request.
REQ-011 Port mb_done, output, NUM_MB bits: sticky flag, frame sent and acknowledged.
REQ-012 Port mb_err, output, NUM_MB bits: sticky flag, retries exhausted or aborted.
REQ-013 Port busy, output, 1 bit: FSM is not in IDLE.
REQ-014 Port cur_mb, output, $clog2(NUM_MB) bits: in-flight mailbox index.
REQ-015 Port irq_done, output, 1 bit: OR of mb_done and mb_err.
REQ-016 Ports core_cs (1 bit), core_rs (2 bits), core_bytesel (4 bits), core_d (32 bits), outputs: master port to the CAN core register interface.
REQ-017 Port core_q, input, 32 bits: combinational read data from the CAN core.

Function
REQ-018 A host write to hreg 00/10/11 SHALL store hwdata into the mailbox, except while that mailbox is in flight; such writes SHALL be dropped.
REQ-019 A hreg 01 write with bit8 set SHALL store the dlc and set pending; if pending is already set, it SHALL have no further effect.
REQ-020 A hreg 01 write with bit9 set SHALL clear pending and set mb_err; if the mailbox is in flight, this SHALL take effect at the end of the attempt.
REQ-021 FSM states SHALL be IDLE, SELECT, LD_ID, LD_D0, LD_D1, STROBE, GAP, POLL, EVAL; every state except POLL lasts exactly one cycle.
REQ-022 IDLE SHALL go to SELECT when any pending bit is set.
REQ-023 SELECT SHALL latch the winner into cur_mb and go to LD_ID.
REQ-024 LD_ID, LD_D0 and LD_D1 SHALL drive core_cs=1, core_bytesel=1111, core_rs = 00/10/11 respectively, and core_d = the mailbox word.
REQ-025 STROBE SHALL drive core_rs=01, core_bytesel=0011, and core_d = {bit8=1, bits3:0=dlc, other bits 0}; bauddiv and irqen in the core SHALL never be written.
REQ-026 GAP SHALL drive core_cs=0 so the core's rts flag registers.
REQ-027 POLL SHALL drive core_cs=1, core_rs=01, core_bytesel=0000, and stay in POLL while core_q[8] (rts)=1.
REQ-028 When core_q[8]=0, POLL SHALL capture lostf=q[9], bitf=q[10] and ackf=q[11], then go to EVAL.
REQ-029 core_rs=00 SHALL never be driven with bytesel=0000, so that receive flags in the core are not cleared.
REQ-030 In EVAL, success (lostf=0, bitf=0, ackf=1) SHALL set mb_done, clear pending, and zero the retry count.
REQ-031 In EVAL, lostf=1 SHALL return to SELECT without consuming a retry.
REQ-032 In EVAL, bitf=1 or ackf=0 SHALL increment the retry count; if the count reaches RETRY_MAX, EVAL SHALL set mb_err and clear pending; otherwise it SHALL return to SELECT.
REQ-033 EVAL SHALL go to IDLE when no pending bits remain, otherwise to SELECT; a pending abort SHALL override success.
REQ-034 core_cs SHALL be 0 in IDLE, SELECT, EVAL and GAP.
REQ-035 If done_clr and a flag set occur in the same cycle, the set SHALL win.

Reset
REQ-036 Reset SHALL clear pending, mb_done, mb_err, retry counts, cur_mb, FSM (to IDLE) and all core_* outputs to 0.
REQ-037 Mailbox ID, data and dlc storage SHALL not be reset.
REQ-038 Reset mid-frame SHALL abandon the frame; the core's own transmission is not recovered by this block.

Configuration
REQ-039 With CAN_TXSCHED_PRIO_EN defined, SELECT SHALL choose the pending mailbox with the lowest key, where key = ext ? {id[28:18],1,id[17:0]} : {id[10:0],0,18'h0}; ties SHALL go to the lower index.
REQ-040 Without CAN_TXSCHED_PRIO_EN, SELECT SHALL be round-robin, starting from the index after the last successful mailbox.

Structure
REQ-041 A shared package SHALL hold the FSM state enum, the hreg codes, the core register-select codes and the core status bit positions (8 to 11).
REQ-042 One sub-module, can_tx_prio_sel, SHALL implement the combinational winner selection for both configurations.

Verification
REQ-043 Load MB0 with std ID 0x123, dlc 2, data0 0xAABB0000, then request; core model acks -> four writes in order (rs 00, 10, 11, 01 with d=0x102), then polling; mb_done[0]=1 and irq_done=1.
REQ-044 With PRIO_EN, MB1 std 0x100 and MB2 ext 0x04000000 both pending -> MB1 sent first (key 0x100<<19 < ext key), then MB2.
REQ-045 Core model returns bitf=1 on every attempt with RETRY_MAX=3 -> exactly 3 strobes, then mb_err[x]=1 and pending cleared.
REQ-046 Core model returns lostf=1 twice, then success -> 3 strobes, mb_done set, mb_err never set.
REQ-047 Abort the in-flight MB0 during POLL -> frame completes and mb_err[0]=1, mb_done[0]=0; an ID write to MB0 during LD_D0 is ignored.
REQ-048 Assert reset in POLL -> next cycle busy=0, core_cs=0, all pending bits 0.
